// File: rtl/uart_pkg.sv
// Shared definitions for the UART echo controller: FSM state encodings and
// the line-ending characters used by the CR->CR+LF expansion.
package uart_pkg;

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_LF   = 2'd1,
        R_WAIT = 2'd2
    } rx_state_e;

    typedef enum logic [1:0] {
        T_IDLE      = 2'd0,
        T_WAIT_BUSY = 2'd1,
        T_WAIT_DONE = 2'd2
    } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO with extra-MSB pointers; head is readable in the same
// cycle so the TX side can launch a byte without an extra fetch cycle.
module uart_sync_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk_50m,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    logic [AW:0] count_reg;
    logic        do_push;
    logic        do_pop;

    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign empty = (wr_ptr_reg == rd_ptr_reg);

    // Fullness is judged before this cycle's pop, so a push into a full FIFO
    // is dropped even when a pop happens alongside it.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign dout  = mem[rd_ptr_reg[AW-1:0]];
    assign count = count_reg;

    always_ff @(posedge clk_50m) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk_50m) begin
        if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_echo_ctrl.sv
// Echo controller: drains the UART receiver into a FIFO and replays the bytes
// through the transmitter, optionally expanding CR into CR+LF.
module uart_echo_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter bit APPEND_LF    = 1'b1,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                     clk_50m,
    input  logic                     clear,
    input  logic                     rx_ready,
    input  logic [7:0]               rx_data,
    output logic                     rx_ready_clr,
    input  logic                     tx_busy,
    output logic [7:0]               tx_data,
    output logic                     tx_wr_en,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);

    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    rx_state_e       rx_state_reg, rx_state_next;
    tx_state_e       tx_state_reg, tx_state_next;
    logic            rx_ready_clr_reg, rx_ready_clr_next;
    logic            tx_wr_en_reg, tx_wr_en_next;
    logic [7:0]      tx_data_reg, tx_data_next;
    logic [TW-1:0]   timer_reg, timer_next;
    logic            overflow_reg, overflow_next;

    logic            push;
    logic            pop;
    logic [7:0]      push_data;
    logic [7:0]      head;
    logic            full;
    logic            empty;

    uart_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_50m (clk_50m),
        .clear   (clear),
        .push    (push),
        .pop     (pop),
        .din     (push_data),
        .dout    (head),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count)
    );

    always_comb begin
        rx_state_next     = rx_state_reg;
        rx_ready_clr_next = 1'b0;
        push              = 1'b0;
        push_data         = rx_data;
        case (rx_state_reg)
            R_IDLE: begin
                if (rx_ready) begin
                    push              = 1'b1;
                    rx_ready_clr_next = 1'b1;
                    rx_state_next     = (APPEND_LF && (rx_data == CR)) ? R_LF : R_WAIT;
                end
            end
            R_LF: begin
                push          = 1'b1;
                push_data     = LF;
                rx_state_next = R_WAIT;
            end
            // Hold off until the receiver drops ready so one byte is never captured twice.
            R_WAIT: begin
                if (!rx_ready) begin
                    rx_state_next = R_IDLE;
                end
            end
            default: rx_state_next = R_IDLE;
        endcase
    end

    always_comb begin
        tx_state_next = tx_state_reg;
        tx_wr_en_next = 1'b0;
        tx_data_next  = tx_data_reg;
        timer_next    = timer_reg;
        pop           = 1'b0;
        case (tx_state_reg)
            T_IDLE: begin
                if (!empty && !tx_busy) begin
                    pop           = 1'b1;
                    tx_wr_en_next = 1'b1;
                    tx_data_next  = head;
                    timer_next    = '0;
                    tx_state_next = T_WAIT_BUSY;
                end
            end
            // A transmitter that never acknowledges must not stall the echo forever.
            T_WAIT_BUSY: begin
                if (tx_busy) begin
                    tx_state_next = T_WAIT_DONE;
                end else if (timer_reg == TW'(BUSY_TIMEOUT - 1)) begin
                    tx_state_next = T_IDLE;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            T_WAIT_DONE: begin
                if (!tx_busy) begin
                    tx_state_next = T_IDLE;
                end
            end
            default: tx_state_next = T_IDLE;
        endcase
    end

    assign overflow_next = overflow_reg | (push & full);

    always_ff @(posedge clk_50m) begin
        if (clear) begin
            rx_state_reg     <= R_IDLE;
            tx_state_reg     <= T_IDLE;
            rx_ready_clr_reg <= 1'b0;
            tx_wr_en_reg     <= 1'b0;
            tx_data_reg      <= 8'h00;
            timer_reg        <= '0;
            overflow_reg     <= 1'b0;
        end else begin
            rx_state_reg     <= rx_state_next;
            tx_state_reg     <= tx_state_next;
            rx_ready_clr_reg <= rx_ready_clr_next;
            tx_wr_en_reg     <= tx_wr_en_next;
            tx_data_reg      <= tx_data_next;
            timer_reg        <= timer_next;
            overflow_reg     <= overflow_next;
        end
    end

    assign rx_ready_clr = rx_ready_clr_reg;
    assign tx_wr_en     = tx_wr_en_reg;
    assign tx_data      = tx_data_reg;
    assign overflow     = overflow_reg;

endmodule

// File: tb/tb_uart_echo_ctrl.sv
// Scoreboard bench for uart_echo_ctrl: instance 0 expands CR, instance 1 does not.
module tb_uart_echo_ctrl;
    import uart_pkg::*;

    localparam int NORMAL = 0;
    localparam int HOLD   = 1;
    localparam int MUTE   = 2;

    logic       clk = 1'b0;
    logic       clear;
    logic       rx_ready     [2];
    logic [7:0] rx_data      [2];
    logic       rx_ready_clr [2];
    logic       tx_busy      [2];
    logic [7:0] tx_data      [2];
    logic       tx_wr_en     [2];
    logic [4:0] fifo_count   [2];
    logic       overflow     [2];

    always #10 clk = ~clk;

    uart_echo_ctrl #(.DEPTH(16), .APPEND_LF(1'b1), .BUSY_TIMEOUT(4)) dut_lf (
        .clk_50m(clk), .clear(clear),
        .rx_ready(rx_ready[0]), .rx_data(rx_data[0]), .rx_ready_clr(rx_ready_clr[0]),
        .tx_busy(tx_busy[0]), .tx_data(tx_data[0]), .tx_wr_en(tx_wr_en[0]),
        .fifo_count(fifo_count[0]), .overflow(overflow[0])
    );

    uart_echo_ctrl #(.DEPTH(16), .APPEND_LF(1'b0), .BUSY_TIMEOUT(4)) dut_raw (
        .clk_50m(clk), .clear(clear),
        .rx_ready(rx_ready[1]), .rx_data(rx_data[1]), .rx_ready_clr(rx_ready_clr[1]),
        .tx_busy(tx_busy[1]), .tx_data(tx_data[1]), .tx_wr_en(tx_wr_en[1]),
        .fifo_count(fifo_count[1]), .overflow(overflow[1])
    );

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    logic [7:0] exp_q [2][$];
    logic [7:0] exp_byte;
    int         tx_mode [2];
    int         busy_len [2];
    int         busy_cnt [2];
    int         clr_count [2];
    int         wr_count [2];
    int         last_clr_cyc [2];
    int         last_wr_cyc [2];
    int         prev_wr_cyc [2];
    logic       prev_wr [2];
    logic       prev_clr [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: busy for busy_len cycles after each write, or forced high/low.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (tx_mode[i] == HOLD) begin
                tx_busy[i] = 1'b1;
                busy_cnt[i] = 0;
            end else if (tx_mode[i] == MUTE) begin
                tx_busy[i] = 1'b0;
                busy_cnt[i] = 0;
            end else if (tx_wr_en[i]) begin
                tx_busy[i] = 1'b1;
                busy_cnt[i] = busy_len[i];
            end else if (busy_cnt[i] > 0) begin
                busy_cnt[i] = busy_cnt[i] - 1;
                if (busy_cnt[i] == 0) tx_busy[i] = 1'b0;
            end else begin
                tx_busy[i] = 1'b0;
            end
        end
    end

    // Monitor: every write strobe pops and checks the next expected byte.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rx_ready_clr[i]) begin
                clr_count[i]++;
                last_clr_cyc[i] = cyc;
                check($sformatf("clr_single_pulse[%0d]", i), {31'b0, prev_clr[i]}, 32'd0);
            end
            if (tx_wr_en[i]) begin
                prev_wr_cyc[i] = last_wr_cyc[i];
                last_wr_cyc[i] = cyc;
                wr_count[i]++;
                check($sformatf("wr_single_pulse[%0d]", i), {31'b0, prev_wr[i]}, 32'd0);
                if (exp_q[i].size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_wr[%0d]: got tx_data=0x%02h, required no write (cycle %0d)",
                             i, tx_data[i], cyc);
                end else begin
                    exp_byte = exp_q[i].pop_front();
                    $display("[TB] dut%0d tx byte 0x%02h expected 0x%02h", i, tx_data[i], exp_byte);
                    check($sformatf("tx_data[%0d]", i), {24'b0, tx_data[i]}, {24'b0, exp_byte});
                end
            end
            prev_wr[i]  = tx_wr_en[i];
            prev_clr[i] = rx_ready_clr[i];
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input int i, input logic [7:0] b, input bit accept);
        int n;
        if (accept) begin
            exp_q[i].push_back(b);
            if (i == 0 && b == CR) exp_q[i].push_back(LF);
        end
        rx_data[i]  = b;
        rx_ready[i] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rx_ready_clr[i] && n < 20);
        check($sformatf("rx_ack[%0d]", i), {31'b0, rx_ready_clr[i]}, 32'd1);
        rx_ready[i] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_drain(input int i, input int budget);
        int n;
        n = 0;
        while (exp_q[i].size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("drain[%0d]", i), exp_q[i].size(), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        int w0;
        clear = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rx_ready[i] = 1'b0;
            rx_data[i]  = 8'h00;
            tx_busy[i]  = 1'b0;
            tx_mode[i]  = NORMAL;
            busy_len[i] = 10;
            busy_cnt[i] = 0;
            clr_count[i] = 0;
            wr_count[i]  = 0;
            last_clr_cyc[i] = 0;
            last_wr_cyc[i]  = 0;
            prev_wr_cyc[i]  = 0;
            prev_wr[i]  = 1'b0;
            prev_clr[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("reset_rx_ready_clr", {31'b0, rx_ready_clr[i]}, 32'd0);
            check("reset_tx_wr_en",     {31'b0, tx_wr_en[i]},     32'd0);
            check("reset_tx_data",      {24'b0, tx_data[i]},      32'd0);
            check("reset_fifo_count",   {27'b0, fifo_count[i]},   32'd0);
            check("reset_overflow",     {31'b0, overflow[i]},     32'd0);
        end
        clear = 1'b0;
        idle(2);

        // Single byte: one ack, write one cycle after the ack, FIFO back to empty.
        c0 = clr_count[0];
        send_byte(0, 8'h41, 1'b1);
        wait_drain(0, 200);
        check("single_clr_count", clr_count[0] - c0, 32'd1);
        check("single_latency", last_wr_cyc[0] - last_clr_cyc[0], 32'd1);
        idle(3);
        check("single_fifo_empty", {27'b0, fifo_count[0]}, 32'd0);
        idle(15);

        // CR expansion on instance 0, plain CR on instance 1.
        send_byte(0, CR, 1'b1);
        wait_drain(0, 400);
        w0 = wr_count[1];
        send_byte(1, CR, 1'b1);
        wait_drain(1, 400);
        idle(30);
        check("no_lf_write_count", wr_count[1] - w0, 32'd1);

        // Busy never rises: four cycles of waiting, then the next byte launches.
        tx_mode[0] = MUTE;
        idle(2);
        send_byte(0, 8'h51, 1'b1);
        send_byte(0, 8'h52, 1'b1);
        wait_drain(0, 200);
        check("timeout_gap", last_wr_cyc[0] - prev_wr_cyc[0], 32'd5);
        idle(10);
        tx_mode[0] = NORMAL;
        idle(2);

        // Overflow: 17 bytes into 16 entries while the transmitter is held busy.
        tx_mode[1] = HOLD;
        idle(3);
        for (int b = 0; b < 17; b++) begin
            send_byte(1, 8'(b), b < 16);
        end
        check("ovf_fifo_count", {27'b0, fifo_count[1]}, 32'd16);
        check("ovf_flag", {31'b0, overflow[1]}, 32'd1);
        busy_len[1] = 3;
        w0 = wr_count[1];
        tx_mode[1] = NORMAL;
        wait_drain(1, 2000);
        idle(20);
        check("ovf_wr_count", wr_count[1] - w0, 32'd16);
        check("ovf_fifo_drained", {27'b0, fifo_count[1]}, 32'd0);
        check("ovf_sticky", {31'b0, overflow[1]}, 32'd1);

        // Reset while the transmitter is busy with three bytes still queued.
        busy_len[0] = 40;
        for (int k = 0; k < 4; k++) begin
            send_byte(0, 8'h61 + 8'(k), 1'b1);
        end
        check("mid_fifo_count", {27'b0, fifo_count[0]}, 32'd3);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("mid_clear_fifo_count", {27'b0, fifo_count[0]}, 32'd0);
        check("mid_clear_overflow", {31'b0, overflow[1]}, 32'd0);
        check("mid_clear_wr_en", {31'b0, tx_wr_en[0]}, 32'd0);
        exp_q[0].delete();
        w0 = wr_count[0];
        idle(60);
        check("mid_no_more_writes", wr_count[0] - w0, 32'd0);

        // Pointer wrap: 40 distinct bytes at full receive rate.
        busy_len[0] = 1;
        idle(5);
        w0 = wr_count[0];
        for (int k = 0; k < 40; k++) begin
            send_byte(0, 8'h80 + 8'(k), 1'b1);
        end
        wait_drain(0, 1000);
        idle(5);
        check("wrap_wr_count", wr_count[0] - w0, 32'd40);
        check("wrap_no_overflow", {31'b0, overflow[0]}, 32'd0);
        check("wrap_fifo_empty", {27'b0, fifo_count[0]}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
